// File: rtl/ysyx_reg_mp_pkg.sv
// Shared constants and helpers for the multi-ported register file.
// Register addresses are always 5 bits wide. Entries at or above REG_NUM do not exist.
package ysyx_reg_mp_pkg;

    localparam int ADDR_W = 5;
    localparam int MAX_RD = 6;
    localparam int MAX_WR = 4;

    // An address is real when it is non-zero and inside the implemented register count.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int reg_num);
        return (addr != {ADDR_W{1'b0}}) && (int'(addr) < reg_num);
    endfunction

endpackage

// File: rtl/ysyx_reg_rdport.sv
// One read port: decodes the address, takes the newest same-cycle write as a bypass,
// and reports a busy operand only when no bypass satisfies it.
module ysyx_reg_rdport
    import ysyx_reg_mp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int NR_WR   = 2
) (
    input  logic [ADDR_W-1:0]                raddr,
    input  logic [NR_WR-1:0]                 wen,
    input  logic [NR_WR-1:0][ADDR_W-1:0]     waddr,
    input  logic [NR_WR-1:0][XLEN-1:0]       wdata,
    input  logic [REG_NUM-1:0][XLEN-1:0]     rf,
    input  logic [REG_NUM-1:0]               busy,
    output logic [XLEN-1:0]                  rdata,
    output logic                             rbusy
);

    logic            valid_s;
    logic            hit_s;
    logic            busy_s;
    logic [XLEN-1:0] stored_s;
    logic [XLEN-1:0] byp_s;

    // Decode, bypass select (higher port index overrides lower) and busy gating.
    always_comb begin
        valid_s  = addr_valid(raddr, REG_NUM);
        hit_s    = 1'b0;
        busy_s   = 1'b0;
        stored_s = {XLEN{1'b0}};
        byp_s    = {XLEN{1'b0}};
        for (int a = 0; a < REG_NUM; a++) begin
            stored_s = (raddr == ADDR_W'(a)) ? rf[a]   : stored_s;
            busy_s   = (raddr == ADDR_W'(a)) ? busy[a] : busy_s;
        end
        for (int i = 0; i < NR_WR; i++) begin
            hit_s = (wen[i] && (waddr[i] == raddr)) ? 1'b1     : hit_s;
            byp_s = (wen[i] && (waddr[i] == raddr)) ? wdata[i] : byp_s;
        end
        rdata = valid_s ? (hit_s ? byp_s : stored_s) : {XLEN{1'b0}};
        rbusy = valid_s & busy_s & ~hit_s;
    end

endmodule

// File: rtl/ysyx_reg_mp.sv
// Multi-ported integer register file with a per-register busy (pending writer) scoreboard.
// Reads are combinational with same-cycle write bypass. Writes and busy updates land at the next edge.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_NUM
`define YSYX_REG_NUM 32
`endif

module ysyx_reg_mp
    import ysyx_reg_mp_pkg::*;
#(
    parameter int XLEN    = `YSYX_XLEN,
    parameter int REG_NUM = `YSYX_REG_NUM,
    parameter int NR_RD   = 2,
    parameter int NR_WR   = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NR_WR-1:0]                 wen,
    input  logic [NR_WR-1:0][ADDR_W-1:0]     waddr,
    input  logic [NR_WR-1:0][XLEN-1:0]       wdata,
    input  logic [NR_RD-1:0][ADDR_W-1:0]     raddr,
    output logic [NR_RD-1:0][XLEN-1:0]       rdata,
    output logic [NR_RD-1:0]                 rbusy,
    input  logic                             alloc_en,
    input  logic [ADDR_W-1:0]                alloc_addr,
    input  logic                             flush
);

    logic [REG_NUM-1:0][XLEN-1:0] rf_r;
    logic [REG_NUM-1:0]           busy_r;
    logic [REG_NUM-1:0]           wr_hit_s;
    logic [REG_NUM-1:0][XLEN-1:0] wr_data_s;
    logic [REG_NUM-1:0]           alloc_hit_s;

    // Merge write ports per register; x0 and absent registers never match.
    always_comb begin
        wr_hit_s    = {REG_NUM{1'b0}};
        wr_data_s   = {(REG_NUM*XLEN){1'b0}};
        alloc_hit_s = {REG_NUM{1'b0}};
        for (int a = 0; a < REG_NUM; a++) begin
            for (int i = 0; i < NR_WR; i++) begin
                wr_hit_s[a]  = (wen[i] && (waddr[i] == ADDR_W'(a)) && addr_valid(waddr[i], REG_NUM))
                               ? 1'b1 : wr_hit_s[a];
                wr_data_s[a] = (wen[i] && (waddr[i] == ADDR_W'(a)) && addr_valid(waddr[i], REG_NUM))
                               ? wdata[i] : wr_data_s[a];
            end
            alloc_hit_s[a] = alloc_en && (alloc_addr == ADDR_W'(a)) && addr_valid(alloc_addr, REG_NUM);
        end
    end

    // Register array and busy bits; a new allocation outranks the write that retires the old one.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_r   <= {(REG_NUM*XLEN){1'b0}};
            busy_r <= {REG_NUM{1'b0}};
        end else begin
            for (int a = 0; a < REG_NUM; a++) begin
                if (wr_hit_s[a]) begin
                    rf_r[a] <= wr_data_s[a];
                end
                if (flush) begin
                    busy_r[a] <= 1'b0;
                end else if (alloc_hit_s[a]) begin
                    busy_r[a] <= 1'b1;
                end else if (wr_hit_s[a]) begin
                    busy_r[a] <= 1'b0;
                end
            end
        end
    end

    for (genvar j = 0; j < NR_RD; j++) begin : g_rd
        ysyx_reg_rdport #(
            .XLEN    (XLEN),
            .REG_NUM (REG_NUM),
            .NR_WR   (NR_WR)
        ) u_rdport (
            .raddr (raddr[j]),
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .rf    (rf_r),
            .busy  (busy_r),
            .rdata (rdata[j]),
            .rbusy (rbusy[j])
        );
    end

endmodule

// File: tb/tb_ysyx_reg_mp.sv
// Scoreboard bench for ysyx_reg_mp (RV32E configuration, 2 read / 2 write ports).
module tb_ysyx_reg_mp;

    logic              clock;
    logic              reset;
    logic [1:0]        wen;
    logic [1:0][4:0]   waddr;
    logic [1:0][31:0]  wdata;
    logic [1:0][4:0]   raddr;
    logic [1:0][31:0]  rdata;
    logic [1:0]        rbusy;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic              flush;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rf [16];

    ysyx_reg_mp #(.XLEN(32), .REG_NUM(16), .NR_RD(2), .NR_WR(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        reset = 1'b0; wen = '0; waddr = '0; wdata = '0; raddr = '0;
        alloc_en = 1'b0; alloc_addr = 5'd0; flush = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1; waddr[p] = a; wdata[p] = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_en = 1'b1; alloc_addr = a;
    endtask

    task automatic rd(input int p, input logic [4:0] a, input logic [31:0] d, input logic b, input string tag);
        exp_t x;
        raddr[p] = a;
        x.port = p; x.data = d; x.busy = b; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        wr(0, 5'd5, 32'h1111_1111);
        alloc(5'd5);
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int r = 1; r < 16; r++) begin
            idle();
            rd(0, 5'(r), 32'h0, 1'b0, $sformatf("reset.x%0d", r));
            rd(1, 5'(16 - r), 32'h0, 1'b0, $sformatf("reset.x%0d", 16 - r));
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_bypass();
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    wr(0, 5'd5, 32'hDEAD_BEEF);
                    rd(0, 5'd5, 32'hDEAD_BEEF, 1'b0, "bypass.same");
                    rd(1, 5'd5, 32'hDEAD_BEEF, 1'b0, "bypass.same");
                end
                default: rd(0, 5'd5, 32'hDEAD_BEEF, 1'b0, "bypass.stored");
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_same_addr();
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    wr(0, 5'd7, 32'h11);
                    wr(1, 5'd7, 32'h22);
                    rd(0, 5'd7, 32'h22, 1'b0, "same_addr.bypass");
                    rd(1, 5'd7, 32'h22, 1'b0, "same_addr.bypass");
                end
                default: rd(1, 5'd7, 32'h22, 1'b0, "same_addr.stored");
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_alloc();
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin alloc(5'd3); rd(0, 5'd3, 32'h0, 1'b0, "alloc.before"); end
                1: begin
                    alloc(5'd3); wr(0, 5'd3, 32'h5);
                    rd(0, 5'd3, 32'h5, 1'b0, "alloc.wr_bypass");
                    rd(1, 5'd3, 32'h5, 1'b0, "alloc.wr_bypass");
                end
                2: rd(0, 5'd3, 32'h5, 1'b1, "alloc.realloc_wins");
                3: begin wr(1, 5'd3, 32'h6); rd(0, 5'd3, 32'h6, 1'b0, "alloc.retire_bypass"); end
                default: rd(1, 5'd3, 32'h6, 1'b0, "alloc.retired");
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin alloc(5'd4); rd(0, 5'd4, 32'h0, 1'b0, "flush.a4"); rd(1, 5'd9, 32'h0, 1'b0, "flush.a4"); end
                1: begin alloc(5'd9); rd(0, 5'd4, 32'h0, 1'b1, "flush.a9"); rd(1, 5'd9, 32'h0, 1'b0, "flush.a9"); end
                2: begin
                    flush = 1'b1; alloc(5'd2); wr(1, 5'd9, 32'h77);
                    rd(0, 5'd4, 32'h0, 1'b1, "flush.cycle");
                    rd(1, 5'd9, 32'h77, 1'b0, "flush.cycle");
                end
                3: begin rd(0, 5'd4, 32'h0, 1'b0, "flush.after"); rd(1, 5'd9, 32'h77, 1'b0, "flush.after"); end
                default: begin rd(0, 5'd2, 32'h0, 1'b0, "flush.alloc_dropped"); rd(1, 5'd9, 32'h77, 1'b0, "flush.after2"); end
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_out_of_range();
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin
                    wr(0, 5'd20, 32'h1234); wr(1, 5'd0, 32'hFFFF); alloc(5'd20);
                    rd(0, 5'd20, 32'h0, 1'b0, "oor.x20_same"); rd(1, 5'd0, 32'h0, 1'b0, "oor.x0_same");
                end
                1: begin rd(0, 5'd20, 32'h0, 1'b0, "oor.x20_next"); rd(1, 5'd0, 32'h0, 1'b0, "oor.x0_next"); end
                default: begin rd(0, 5'd4, 32'h0, 1'b0, "oor.no_alias"); rd(1, 5'd7, 32'h22, 1'b0, "oor.x7_kept"); end
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    // Random two-port traffic predicted by a behavioural model of the register contents.
    task automatic test_back_to_back();
        logic [31:0] exp_d;
        logic [4:0]  a;
        for (int r = 0; r < 16; r++) model_rf[r] = 32'h0;
        model_rf[3] = 32'h6; model_rf[5] = 32'hDEAD_BEEF; model_rf[7] = 32'h22; model_rf[9] = 32'h77;
        for (int c = 0; c < 60; c++) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) != 0) wr(i, 5'($urandom_range(0, 20)), $urandom);
            end
            for (int j = 0; j < 2; j++) begin
                a = ($urandom_range(0, 1) == 1) ? waddr[$urandom_range(0, 1)] : 5'($urandom_range(0, 20));
                exp_d = 32'h0;
                if (a != 5'd0 && a < 5'd16) begin
                    exp_d = model_rf[a[3:0]];
                    for (int i = 0; i < 2; i++) if (wen[i] && waddr[i] == a) exp_d = wdata[i];
                end
                rd(j, a, exp_d, 1'b0, $sformatf("b2b.c%0d.x%0d", c, a));
            end
            for (int i = 0; i < 2; i++) begin
                if (wen[i] && waddr[i] != 5'd0 && waddr[i] < 5'd16) model_rf[waddr[i][3:0]] = wdata[i];
            end
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_priority();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin wr(0, 5'd5, 32'hA5A5); alloc(5'd6); rd(0, 5'd5, 32'hA5A5, 1'b0, "rstpri.pre"); end
                1: begin reset = 1'b1; wr(1, 5'd7, 32'h99); alloc(5'd8); flush = 1'b1; end
                2: begin rd(0, 5'd5, 32'h0, 1'b0, "rstpri.x5"); rd(1, 5'd6, 32'h0, 1'b0, "rstpri.x6"); end
                default: begin rd(0, 5'd7, 32'h0, 1'b0, "rstpri.x7"); rd(1, 5'd8, 32'h0, 1'b0, "rstpri.x8"); end
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({rbusy[e.port], rdata[e.port]} !== {e.busy, e.data}) begin
                    n_fail++;
                    $display("FAIL %s port%0d: got rdata=%h rbusy=%b, required rdata=%h rbusy=%b",
                             e.tag, e.port, rdata[e.port], rbusy[e.port], e.data, e.busy);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_same_addr();
        test_alloc();
        test_flush();
        test_out_of_range();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_reg_mp.md
YSYX_REG_MP -- requirements
Module: ysyx_reg_mp

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN (32): data width.
REQ-002 SHALL have parameter REG_NUM, default `YSYX_REG_NUM: architectural register count, 16 (RV32E) or 32 (RV32I).
REQ-003 SHALL have parameter NR_RD, default 2: read port count, range 1..6.
REQ-004 SHALL have parameter NR_WR, default 2: write port count, range 1..4.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named clock and reset.
REQ-006 SHALL have port clock  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port wen  input  NR_WR  per-port write enable.
REQ-009 SHALL have port waddr  input  NR_WR x 5  per-port write address.
REQ-010 SHALL have port wdata  input  NR_WR x XLEN  per-port write data.
REQ-011 SHALL have port raddr  input  NR_RD x 5  per-port read address.
REQ-012 SHALL have port rdata  output  NR_RD x XLEN  per-port read data, combinational.
REQ-013 SHALL have port rbusy  output  NR_RD  per-port busy (pending writer) flag, combinational.
REQ-014 SHALL have port alloc_en  input  1  mark destination register busy (dispatch).
REQ-015 SHALL have port alloc_addr  input  5  destination register being allocated.
REQ-016 SHALL have port flush  input  1  clear all busy bits (pipeline flush).

Function
REQ-017 SHALL read address 0 as 0 and SHALL read addresses >= REG_NUM as 0, with rbusy 0 in both cases.
REQ-018 SHALL ignore writes to address 0 and to addresses >= REG_NUM.
REQ-019 SHALL update rf[a] at the clock edge after the cycle where wen[i]=1 and waddr[i]=a.
REQ-020 SHALL, when several write ports target the same address in one cycle, store the data of the highest-index port.
REQ-021 SHALL bypass same-cycle writes: rdata[j] equals wdata of the highest-index enabled port with waddr equal to raddr[j], otherwise the stored rf value.
REQ-022 SHALL keep one busy bit per register; busy[0] and busy of addresses >= REG_NUM SHALL always be 0.
REQ-023 SHALL set busy[alloc_addr] at the next edge when alloc_en=1 and flush=0.
REQ-024 SHALL clear busy[a] at the next edge when any enabled write port targets a, unless alloc_en=1 with alloc_addr=a in the same cycle, in which case busy stays 1 (the newer allocation wins).
REQ-025 SHALL clear all busy bits at the next edge when flush=1, overriding alloc_en; writes in a flush cycle SHALL still update rf.
REQ-026 SHALL drive rbusy[j] = busy[raddr[j]] AND NOT (any same-cycle write to raddr[j]), so bypassed operands read as ready.
REQ-027 SHALL have zero-cycle read latency and one-cycle write latency.

Reset
REQ-028 SHALL clear all rf entries and all busy bits at the edge where reset=1; rdata SHALL read 0 and rbusy 0 in the following cycle.
REQ-029 SHALL give reset priority over wen, alloc_en and flush in the same cycle.

Structure
REQ-030 SHALL take XLEN and REG_NUM defaults from the shared ysyx.svh header; no new package types are required.
REQ-031 SHALL implement each read port (address decode, bypass priority select, busy gating) in one sub-module ysyx_reg_rdport, instantiated NR_RD times via generate.
REQ-032 SHALL instantiate the write merge and busy update logic once in the top module.

Verification
REQ-033 SHALL cover: reset, then read x1..x15 -> all rdata 0, all rbusy 0.
REQ-034 SHALL cover: wen[0]=1 waddr=5 wdata=0xDEADBEEF, raddr[0]=5 in the same cycle -> rdata[0]=0xDEADBEEF (bypass); next cycle without write -> still 0xDEADBEEF.
REQ-035 SHALL cover: ports 0 and 1 both write x7 with 0x11 and 0x22 -> same-cycle rdata=0x22, stored x7=0x22.
REQ-036 SHALL cover: alloc x3 -> rbusy=1 next cycle; write x3=0x5 with alloc x3 in the same cycle -> rbusy remains 1 with rdata 0x5; write x3 alone -> rbusy 0.
REQ-037 SHALL cover: allocate x4, x9, then flush with wen writing x9=0x77 -> busy all 0, x9=0x77.
REQ-038 SHALL cover: with REG_NUM=16, write x20=0x1234 -> ignored, raddr=20 reads 0; write x0=0xFFFF -> x0 reads 0.
